// File: rtl/pixel_pkg.sv
// Shared constants and width helpers for the pixel block averager.
// Supplies the clog2 helper, the accumulator width and the rounding mode codes.
package pixel_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A FACTOR x FACTOR block sum needs 2*log2(FACTOR) bits of headroom.
  function automatic int sum_w(input int resolution, input int factor);
    return resolution + 2 * clog2(factor);
  endfunction

endpackage

// File: rtl/line_acc_ram.sv
// Partial block sums for one row of blocks: combinational read, registered write.
// Contents are not reset; the first row of every block row overwrites them.
module line_acc_ram
  import pixel_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int WIDTH = 12,
  parameter int AW    = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_dat_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pixel_block_averager.sv
// Streaming FACTOR x FACTOR box-filter downsampler; result registered one cycle after the block's last pixel.
// Input is stalled (in_ready low) while an output is held by downstream backpressure.
module pixel_block_averager
  import pixel_pkg::*;
#(
  parameter int RESOLUTION = 8,
  parameter int IN_WIDTH   = 56,
  parameter int IN_HEIGHT  = 56,
  parameter int FACTOR     = 2,
  parameter int ROUND      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RESOLUTION-1:0] in_pixel,
  input  logic                  in_sof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RESOLUTION-1:0] out_pixel,
  output logic                  out_last
);

  localparam int LOG2F = clog2(FACTOR);
  localparam int SUM_W = sum_w(RESOLUTION, FACTOR);
  localparam int DEPTH = IN_WIDTH / FACTOR;
  localparam int AW    = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW    = clog2(IN_WIDTH);
  localparam int RW    = clog2(IN_HEIGHT);
  localparam int RND   = (ROUND == ROUND_HALF_UP) ? (1 << (2 * LOG2F - 1)) : 0;

  localparam logic [CW-1:0] COL_MASK = CW'(FACTOR - 1);
  localparam logic [RW-1:0] ROW_MASK = RW'(FACTOR - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IN_HEIGHT - 1);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [SUM_W-1:0]      hsum_q, hsum_d;
  logic                  out_valid_q, out_valid_d;
  logic [RESOLUTION-1:0] out_pixel_q, out_pixel_d;
  logic                  out_last_q, out_last_d;

  logic             accept;
  logic [CW-1:0]    eff_col;
  logic [RW-1:0]    eff_row;
  logic             first_col, last_col, first_row, last_row;
  logic             end_of_row, end_of_frame;
  logic [AW-1:0]    blk;
  logic [SUM_W-1:0] pix_ext, hsum_in, acc_rd, total, rounded;
  logic             acc_we;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel restarts the raster wherever the counters were.
  assign eff_col = in_sof ? '0 : col_q;
  assign eff_row = in_sof ? '0 : row_q;

  assign first_col    = (eff_col & COL_MASK) == '0;
  assign last_col     = (eff_col & COL_MASK) == COL_MASK;
  assign first_row    = (eff_row & ROW_MASK) == '0;
  assign last_row     = (eff_row & ROW_MASK) == ROW_MASK;
  assign end_of_row   = eff_col == COL_MAX;
  assign end_of_frame = end_of_row && (eff_row == ROW_MAX);
  assign blk          = AW'(eff_col >> LOG2F);

  assign pix_ext = SUM_W'(in_pixel);
  assign hsum_in = first_col ? pix_ext : hsum_q + pix_ext;
  assign total   = hsum_in + (first_row ? '0 : acc_rd);
  assign rounded = total + SUM_W'(RND);
  assign acc_we  = accept && last_col && !last_row;

  line_acc_ram #(
    .DEPTH (DEPTH),
    .WIDTH (SUM_W),
    .AW    (AW)
  ) u_acc (
    .clk       (clk),
    .wr_en_i   (acc_we),
    .wr_addr_i (blk),
    .wr_dat_i  (total),
    .rd_addr_i (blk),
    .rd_dat_o  (acc_rd)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hsum_d      = hsum_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_last_d  = out_last_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (accept) begin
      hsum_d = hsum_in;
      if (end_of_row) begin
        col_d = '0;
        row_d = end_of_frame ? '0 : eff_row + RW'(1);
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end
      // A completing block overrides the transfer clear above, keeping out_valid high.
      if (last_col && last_row) begin
        out_valid_d = 1'b1;
        out_pixel_d = RESOLUTION'(rounded >> (2 * LOG2F));
        out_last_d  = end_of_frame;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      hsum_q      <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hsum_q      <= hsum_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pixel_block_averager.sv
// Bench for pixel_block_averager: four instances (4x4/F2 and 8x8/F4, each in both round modes).
// Table-driven frames plus hand sequences for backpressure, mid-frame sof and mid-frame reset.
module tb_pixel_block_averager;

  typedef struct packed {
    logic [1:0]      inst;
    logic [1:0]      pat;
    logic [3:0][7:0] exp;
  } vec_t;

  typedef struct packed {
    logic [1:0] inst;
    logic [7:0] pix;
    logic       last;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid  [4];
  logic       in_ready  [4];
  logic [7:0] in_pixel  [4];
  logic       in_sof    [4];
  logic       out_valid [4];
  logic       out_ready [4];
  logic [7:0] out_pixel [4];
  logic       out_last  [4];

  int         tests_run    = 0;
  int         tests_failed = 0;
  sb_t        sb[$];
  logic [7:0] rp [16];
  vec_t       tbl [8];

  always #5 clk = ~clk;

  pixel_block_averager #(.RESOLUTION(8), .IN_WIDTH(4), .IN_HEIGHT(4), .FACTOR(2), .ROUND(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_pixel(in_pixel[0]),
    .in_sof(in_sof[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_pixel(out_pixel[0]),
    .out_last(out_last[0]));
  pixel_block_averager #(.RESOLUTION(8), .IN_WIDTH(4), .IN_HEIGHT(4), .FACTOR(2), .ROUND(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_pixel(in_pixel[1]),
    .in_sof(in_sof[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_pixel(out_pixel[1]),
    .out_last(out_last[1]));
  pixel_block_averager #(.RESOLUTION(8), .IN_WIDTH(8), .IN_HEIGHT(8), .FACTOR(4), .ROUND(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_pixel(in_pixel[2]),
    .in_sof(in_sof[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_pixel(out_pixel[2]),
    .out_last(out_last[2]));
  pixel_block_averager #(.RESOLUTION(8), .IN_WIDTH(8), .IN_HEIGHT(8), .FACTOR(4), .ROUND(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_pixel(in_pixel[3]),
    .in_sof(in_sof[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_pixel(out_pixel[3]),
    .out_last(out_last[3]));

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int inst, input int pat, input int e0, input int e1,
                              input int e2, input int e3);
    vec_t v;
    v.inst = 2'(inst);
    v.pat  = 2'(pat);
    v.exp  = {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    return v;
  endfunction

  function automatic logic [7:0] pix_of(input int pat, input int idx);
    case (pat)
      0:       return 8'(idx);
      1:       return rp[idx];
      default: return 8'd255;
    endcase
  endfunction

  // Transfers are observed on the falling edge ahead of the rising edge that completes them.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (sb.size() == 0) begin
            check("unexpected_output", int'(out_pixel[i]), -1);
          end else begin
            sb_t e;
            e = sb.pop_front();
            check("out_inst", i, int'(e.inst));
            check("out_pixel", int'(out_pixel[i]), int'(e.pix));
            check("out_last", int'(out_last[i]), int'(e.last));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_pixel(input int inst, input logic [7:0] p, input logic sof);
    int n;
    in_valid[inst] = 1'b1;
    in_pixel[inst] = p;
    in_sof[inst]   = sof;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready[inst] && n < 50);
    if (!in_ready[inst]) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid[inst] = 1'b0;
    in_sof[inst]   = 1'b0;
  endtask

  task automatic send_frame(input int inst, input int pat, input logic [3:0][7:0] exp,
                            input int bp, input bit use_sof);
    int w;
    int f;
    int k;
    w = (inst < 2) ? 4 : 8;
    f = (inst < 2) ? 2 : 4;
    k = 0;
    for (int idx = 0; idx < w * w; idx++) begin
      bit fin;
      fin = ((idx % w) % f == f - 1) && ((idx / w) % f == f - 1);
      if (fin) begin
        sb.push_back('{inst: 2'(inst), pix: exp[k], last: (k == 3)});
        k++;
      end
      drive_pixel(inst, pix_of(pat, idx), use_sof && (idx == 0));
      check("latency_out_valid", int'(out_valid[inst]), int'(fin));
      if (fin && k == 1 && bp > 0) begin
        out_ready[inst] = 1'b0;
        in_valid[inst]  = 1'b1;
        in_pixel[inst]  = pix_of(pat, idx + 1);
        repeat (bp) begin
          @(negedge clk);
          check("bp_in_ready", int'(in_ready[inst]), 0);
          check("bp_out_valid", int'(out_valid[inst]), 1);
          check("bp_out_pixel", int'(out_pixel[inst]), int'(exp[0]));
        end
        @(posedge clk);
        #1;
        out_ready[inst] = 1'b1;
      end
    end
  endtask

  initial begin
    rp = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd2, 8'd2, 8'd3, 8'd4,
           8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd1, 8'd255, 8'd254};
    tbl[0] = mk(0, 0, 2, 4, 10, 12);
    tbl[1] = mk(1, 0, 3, 5, 11, 13);
    tbl[2] = mk(0, 1, 1, 3, 0, 254);
    tbl[3] = mk(1, 1, 2, 3, 0, 255);
    tbl[4] = mk(2, 2, 255, 255, 255, 255);
    tbl[5] = mk(3, 2, 255, 255, 255, 255);
    tbl[6] = mk(2, 0, 13, 17, 45, 49);
    tbl[7] = mk(3, 0, 14, 18, 46, 50);
    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      in_pixel[i]  = 8'd0;
      in_sof[i]    = 1'b0;
      out_ready[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("reset_out_valid", int'(out_valid[i]), 0);
      check("reset_out_pixel", int'(out_pixel[i]), 0);
      check("reset_out_last", int'(out_last[i]), 0);
      check("reset_in_ready", int'(in_ready[i]), 1);
    end

    for (int t = 0; t < 8; t++) begin
      send_frame(int'(tbl[t].inst), int'(tbl[t].pat), tbl[t].exp, 0, 1'b1);
    end

    // Downstream stalls for five cycles right after the first result.
    send_frame(0, 0, tbl[0].exp, 5, 1'b1);

    // Partial junk frame on the 8x8 instance, then sof restarts the raster at col 6.
    for (int i = 0; i < 6; i++) begin
      drive_pixel(2, 8'd100, i == 0);
    end
    send_frame(2, 0, tbl[6].exp, 0, 1'b1);

    // Mid-frame reset while a result is being held, then a frame without sof.
    for (int i = 0; i < 6; i++) begin
      drive_pixel(0, 8'(i), i == 0);
      if (i == 5) out_ready[0] = 1'b0;
    end
    check("held_out_valid", int'(out_valid[0]), 1);
    check("held_out_pixel", int'(out_pixel[0]), 2);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid[0]), 0);
    check("arst_out_pixel", int'(out_pixel[0]), 0);
    check("arst_out_last", int'(out_last[0]), 0);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    out_ready[0] = 1'b1;
    send_frame(0, 0, tbl[0].exp, 0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
